// File: rtl/serial_key_decoder.sv
// serial_key_decoder
//
// Serial unlock decoder for the binary calculator controller. A frame of
// KEY_W key bits followed by MODE_W mode bits arrives LSB first, one bit per
// validCmd cycle. A key matching KEY_VAL unlocks the decoder (active=1) and
// publishes the mode field. While unlocked, further MODE_W-bit frames update
// the mode. MAX_FAIL consecutive bad keys lock the decoder for LOCK_CYCLES
// cycles.
//
// Optional build macro: SKD_TIMEOUT_EN
//   When defined, a partial frame with no validCmd for TIMEOUT consecutive
//   cycles is discarded. When undefined, partial frames are held
//   indefinitely and no idle counter exists.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   inputKey  in   serial data bit, sampled when validCmd=1
//   validCmd  in   bit qualifier, one bit per cycle while high
//   clear     in   ends an active session / discards a partial frame
//   active    out  unlocked indication (registered)
//   mode      out  current mode, MODE_W bits (registered)
//   keyError  out  one-cycle pulse on a key mismatch
//   locked    out  high during lockout
//
// Handshake: there is no back-pressure. A bit is transferred on every rising
// edge where validCmd=1; in LOCKED validCmd is ignored, and in RX_KEY/ACTIVE
// clear takes priority over a coincident validCmd.
module serial_key_decoder #(
    parameter int              KEY_W       = 4,
    parameter logic [KEY_W-1:0] KEY_VAL    = 4'b0101,
    parameter int              MODE_W      = 2,
    parameter int              MAX_FAIL    = 3,
    parameter int              LOCK_CYCLES = 16,
    parameter int              TIMEOUT     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inputKey,
    input  logic              validCmd,
    input  logic              clear,
    output logic              active,
    output logic [MODE_W-1:0] mode,
    output logic              keyError,
    output logic              locked
);

    localparam int FRAME_W = KEY_W + MODE_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int LOCK_W  = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        RX_KEY = 2'd0,
        ACTIVE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FAIL_W-1:0]    fail_cnt_q, fail_cnt_d;
    logic [FAIL_W-1:0]    fail_inc;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [FRAME_W-1:0]   frame_full;
    logic [LOCK_W-1:0]    lock_q, lock_d;
    logic                 active_q, active_d;
    logic [MODE_W-1:0]    mode_q, mode_d;
    logic                 key_error_q, key_error_d;
    logic                 locked_q, locked_d;

`ifdef SKD_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0]    idle_q, idle_d;
`else
    // TIMEOUT only matters when the idle counter is built.
    logic                 unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    assign fail_inc = fail_cnt_q + FAIL_W'(1);

    // Frame as it would look with the incoming bit written at its position.
    // Lets the last bit be evaluated on the same edge that samples it.
    always_comb begin
        frame_full = frame_q;
        for (int i = 0; i < FRAME_W; i++) begin
            if (bit_cnt_q == CNT_W'(i)) frame_full[i] = inputKey;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        frame_d     = frame_q;
        lock_d      = lock_q;
        active_d    = active_q;
        mode_d      = mode_q;
        key_error_d = 1'b0;
        locked_d    = locked_q;
`ifdef SKD_TIMEOUT_EN
        idle_d      = idle_q;
`endif

        unique case (state_q)
            RX_KEY: begin
                if (clear) begin
                    // Partial frame dropped; failure history survives.
                    bit_cnt_d = '0;
                    frame_d   = '0;
                end else if (validCmd) begin
                    if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                        bit_cnt_d = '0;
                        frame_d   = '0;
                        if (frame_full[KEY_W-1:0] == KEY_VAL) begin
                            state_d    = ACTIVE;
                            active_d   = 1'b1;
                            mode_d     = frame_full[FRAME_W-1:KEY_W];
                            fail_cnt_d = '0;
                        end else begin
                            key_error_d = 1'b1;
                            fail_cnt_d  = fail_inc;
                            if (fail_inc == FAIL_W'(MAX_FAIL)) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                                lock_d   = LOCK_W'(LOCK_CYCLES);
                            end
                        end
                    end else begin
                        frame_d   = frame_full;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end

            ACTIVE: begin
                if (clear) begin
                    state_d    = RX_KEY;
                    active_d   = 1'b0;
                    mode_d     = '0;
                    bit_cnt_d  = '0;
                    frame_d    = '0;
                    fail_cnt_d = '0;
                end else if (validCmd) begin
                    // Mode bits accumulate in frame_q; mode itself only
                    // changes once the whole field is present.
                    if (bit_cnt_q == CNT_W'(MODE_W - 1)) begin
                        mode_d    = frame_full[MODE_W-1:0];
                        bit_cnt_d = '0;
                        frame_d   = '0;
                    end else begin
                        frame_d   = frame_full;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end

            LOCKED: begin
                // Timer loaded with LOCK_CYCLES; leaving when it reads 1
                // keeps locked high for exactly LOCK_CYCLES cycles.
                if (lock_q == LOCK_W'(1)) begin
                    state_d    = RX_KEY;
                    locked_d   = 1'b0;
                    fail_cnt_d = '0;
                    lock_d     = '0;
                end else begin
                    lock_d = lock_q - LOCK_W'(1);
                end
            end

            default: begin
                state_d = RX_KEY;
            end
        endcase

`ifdef SKD_TIMEOUT_EN
        // Only idle cycles with a partial frame advance the counter; any
        // bit, clear or empty frame restarts it.
        if (state_q == LOCKED || validCmd || clear || bit_cnt_q == '0) begin
            idle_d = '0;
        end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            idle_d    = '0;
            bit_cnt_d = '0;
            frame_d   = '0;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RX_KEY;
            bit_cnt_q   <= '0;
            fail_cnt_q  <= '0;
            frame_q     <= '0;
            lock_q      <= '0;
            active_q    <= 1'b0;
            mode_q      <= '0;
            key_error_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            frame_q     <= frame_d;
            lock_q      <= lock_d;
            active_q    <= active_d;
            mode_q      <= mode_d;
            key_error_q <= key_error_d;
            locked_q    <= locked_d;
        end
    end

`ifdef SKD_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) idle_q <= '0;
        else          idle_q <= idle_d;
    end
`endif

    assign active   = active_q;
    assign mode     = mode_q;
    assign keyError = key_error_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_serial_key_decoder.sv
// Testbench for serial_key_decoder (default parameters: KEY_W=4,
// KEY_VAL=4'b0101, MODE_W=2, MAX_FAIL=3, LOCK_CYCLES=16, TIMEOUT=32).
// Frames are written as 6-bit values whose bit k is the k-th bit sent.
module tb_serial_key_decoder;

    localparam int          LOCK = 16;
    localparam logic [5:0]  BAD  = 6'b000100;  // key 0100

    logic       clk = 1'b0;
    logic       reset_n;
    logic       inputKey;
    logic       validCmd;
    logic       clear;
    logic       active;
    logic [1:0] mode;
    logic       keyError;
    logic       locked;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] frame;
        logic       exp_active;
        logic [1:0] exp_mode;
        logic       exp_kerr;
    } vec_t;

    vec_t vecs[8];

    serial_key_decoder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .inputKey (inputKey),
        .validCmd (validCmd),
        .clear    (clear),
        .active   (active),
        .mode     (mode),
        .keyError (keyError),
        .locked   (locked)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        validCmd = 1'b1;
        inputKey = b;
        tick();
        validCmd = 1'b0;
        inputKey = 1'b0;
    endtask

    task automatic send_frame(input logic [5:0] f);
        for (int i = 0; i < 6; i++) send_bit(f[i]);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        tick();
    endtask

    // ---------------- stimulus + checks ----------------
    initial begin
        logic [5:0] good;
        logic [5:0] f01;

        vecs[0] = '{6'b110101, 1'b1, 2'b11, 1'b0};
        vecs[1] = '{6'b000100, 1'b0, 2'b00, 1'b1};
        vecs[2] = '{6'b100101, 1'b1, 2'b10, 1'b0};
        vecs[3] = '{6'b111111, 1'b0, 2'b00, 1'b1};
        vecs[4] = '{6'b001010, 1'b0, 2'b00, 1'b1};
        vecs[5] = '{6'b010101, 1'b1, 2'b01, 1'b0};
        vecs[6] = '{6'b000000, 1'b0, 2'b00, 1'b1};
        vecs[7] = '{6'b000101, 1'b1, 2'b00, 1'b0};
        good = 6'b110101;
        f01  = 6'b010101;

        reset_n  = 1'b0;
        inputKey = 1'b0;
        validCmd = 1'b0;
        clear    = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst active", {7'b0, active}, 8'd0);
        check("rst mode", {6'b0, mode}, 8'd0);
        check("rst keyError", {7'b0, keyError}, 8'd0);
        check("rst locked", {7'b0, locked}, 8'd0);
        reset_n = 1'b1;
        tick();

        // Table-driven frames; failure count never reaches MAX_FAIL here
        // because every bad run is broken by a good key.
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].frame);
            check($sformatf("vec%0d active", i), {7'b0, active}, {7'b0, vecs[i].exp_active});
            check($sformatf("vec%0d mode", i), {6'b0, mode}, {6'b0, vecs[i].exp_mode});
            check($sformatf("vec%0d keyError", i), {7'b0, keyError}, {7'b0, vecs[i].exp_kerr});
            check($sformatf("vec%0d locked", i), {7'b0, locked}, 8'd0);
            tick();
            check($sformatf("vec%0d keyError drop", i), {7'b0, keyError}, 8'd0);
            check($sformatf("vec%0d active hold", i), {7'b0, active}, {7'b0, vecs[i].exp_active});
            do_clear();
            check($sformatf("vec%0d clr active", i), {7'b0, active}, 8'd0);
            check($sformatf("vec%0d clr mode", i), {6'b0, mode}, 8'd0);
        end

        // Lockout: three bad frames
        do_reset();
        send_frame(BAD);
        check("lk bad1 locked", {7'b0, locked}, 8'd0);
        send_frame(BAD);
        check("lk bad2 locked", {7'b0, locked}, 8'd0);
        send_frame(BAD);
        check("lk bad3 locked", {7'b0, locked}, 8'd1);
        check("lk bad3 keyError", {7'b0, keyError}, 8'd1);
        // Correct frame and a clear during lockout are ignored
        for (int k = 1; k <= LOCK; k++) begin
            if (k <= 6) begin
                validCmd = 1'b1;
                inputKey = good[k-1];
            end
            if (k == 8) clear = 1'b1;
            tick();
            validCmd = 1'b0;
            inputKey = 1'b0;
            clear    = 1'b0;
            if (k == 6) check("lk ignore active", {7'b0, active}, 8'd0);
            if (k == 2) check("lk keyError pulse", {7'b0, keyError}, 8'd0);
            if (k == LOCK - 1) check("lk still locked", {7'b0, locked}, 8'd1);
            if (k == LOCK) check("lk released", {7'b0, locked}, 8'd0);
        end
        send_frame(good);
        check("lk after active", {7'b0, active}, 8'd1);
        check("lk after mode", {6'b0, mode}, 8'd3);

        // In-session mode update: 1 then 0 -> 2'b01, no partial value
        send_bit(1'b1);
        check("mu partial mode", {6'b0, mode}, 8'd3);
        check("mu partial active", {7'b0, active}, 8'd1);
        send_bit(1'b0);
        check("mu new mode", {6'b0, mode}, 8'd1);

        // clear and validCmd together: clear wins, bit discarded
        clear    = 1'b1;
        validCmd = 1'b1;
        inputKey = 1'b1;
        tick();
        clear    = 1'b0;
        validCmd = 1'b0;
        inputKey = 1'b0;
        check("cv active", {7'b0, active}, 8'd0);
        check("cv mode", {6'b0, mode}, 8'd0);
        for (int i = 0; i < 5; i++) send_bit(f01[i]);
        check("cv 5th bit active", {7'b0, active}, 8'd0);
        check("cv 5th bit keyError", {7'b0, keyError}, 8'd0);
        send_bit(f01[5]);
        check("cv frame active", {7'b0, active}, 8'd1);
        check("cv frame mode", {6'b0, mode}, 8'd1);

        // clear in RX_KEY discards a partial frame
        do_clear();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        do_clear();
        send_frame(good);
        check("cp active", {7'b0, active}, 8'd1);
        check("cp keyError", {7'b0, keyError}, 8'd0);

        // clear in RX_KEY keeps the failure count
        do_clear();
        send_frame(BAD);
        send_frame(BAD);
        send_bit(1'b1);
        do_clear();
        check("fk locked before", {7'b0, locked}, 8'd0);
        send_frame(BAD);
        check("fk locked", {7'b0, locked}, 8'd1);
        for (int k = 1; k <= LOCK; k++) tick();
        check("fk released", {7'b0, locked}, 8'd0);

        // Asynchronous reset from ACTIVE, then mid-frame
        send_frame(good);
        send_bit(1'b1);
        reset_n = 1'b0;
        #2;
        check("ar active", {7'b0, active}, 8'd0);
        check("ar mode", {6'b0, mode}, 8'd0);
        reset_n = 1'b1;
        tick();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        do_reset();
        send_frame(f01);
        check("ar frame active", {7'b0, active}, 8'd1);
        check("ar frame mode", {6'b0, mode}, 8'd1);

        // Idle partial frame
        do_reset();
`ifdef SKD_TIMEOUT_EN
        send_bit(1'b1);
        send_bit(1'b0);
        for (int k = 0; k < 32; k++) tick();
        for (int i = 0; i < 4; i++) send_bit(good[i]);
        check("to 4th bit active", {7'b0, active}, 8'd0);
        send_bit(good[4]);
        send_bit(good[5]);
        check("to frame active", {7'b0, active}, 8'd1);
        check("to frame mode", {6'b0, mode}, 8'd3);
`else
        send_bit(1'b0);
        send_bit(1'b0);
        for (int k = 0; k < 40; k++) tick();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("hold keyError", {7'b0, keyError}, 8'd1);
        check("hold active", {7'b0, active}, 8'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_key_decoder.md
Name: serial_key_decoder

Overview:
Parametrised successor of the single-key serial unlock decoder for the binary calculator controller. It collects a serial frame of key bits followed by mode bits, qualified by validCmd, and compares the key field with a parameter value. On a match it asserts active and presents a multi-bit mode. It adds failed-attempt counting with a timed lockout, an explicit re-arm input and in-session mode updates; its outputs feed the controller's RW flow block.

Parameters:
KEY_W, 4, key field width in bits (>=1)
KEY_VAL, 4'b0101, expected key; frame bit k is compared with KEY_VAL[k]
MODE_W, 2, mode field width in bits (>=1)
MAX_FAIL, 3, consecutive mismatches that trigger lockout (>=1)
LOCK_CYCLES, 16, lockout duration in clk cycles (>=1)
TIMEOUT, 32, inter-bit idle limit in cycles; used only with the optional feature

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
inputKey  input  1  serial data bit, sampled only when validCmd=1
validCmd  input  1  bit qualifier; one bit per cycle while high
clear  input  1  ends an active session and re-arms the decoder
active  output  1  unlocked indication, registered
mode  output  MODE_W  current mode, registered
keyError  output  1  one-cycle pulse on a key mismatch
locked  output  1  high while in lockout

Behaviour:
- Reset (reset_n=0, asynchronous): state RX_KEY. Bit counter, failure counter, shift register and lock timer cleared. active=0, mode=0, keyError=0, locked=0.
- Frame format: KEY_W+MODE_W bits, LSB first. Valid bit k (0-based) goes to frame[k]. frame[KEY_W-1:0] is the key; frame[KEY_W+MODE_W-1:KEY_W] is the mode.
- Bit counter width: $clog2(KEY_W+MODE_W+1).
- RX_KEY:
  - Each validCmd cycle stores inputKey and increments the bit counter.
  - The final bit is evaluated on the same clock edge that samples it, with the incoming bit used combinationally. Outputs change at that edge, so latency is 0 cycles after the last sampled edge.
  - Key match: go to ACTIVE, active=1, mode=received mode field, failure counter=0, bit counter=0.
  - Key mismatch: keyError=1 for exactly one cycle, failure counter increments, bit counter=0, shift register discarded.
  - If the incremented failure count equals MAX_FAIL: go to LOCKED, locked=1, lock timer loaded with LOCK_CYCLES. Otherwise stay in RX_KEY.
- ACTIVE:
  - active held at 1.
  - validCmd bits collect a new MODE_W-bit frame, LSB first.
  - On the edge sampling the MODE_W-th bit, mode updates atomically. No partial mode value is ever visible.
  - clear=1: go to RX_KEY next edge, active=0, mode=0, counters cleared. If clear and validCmd occur together, clear wins and the bit is discarded.
- LOCKED:
  - validCmd and clear are ignored.
  - Lock timer decrements each cycle.
  - After exactly LOCK_CYCLES cycles with locked=1: locked=0, failure counter=0, go to RX_KEY.
- clear in RX_KEY: discards any partial frame and keeps the failure count.
- keyError is low in every cycle other than its mismatch pulse.
- reset_n asserted in any state, including mid-frame: immediate return to reset values.

Optional Feature:
Macro SKD_TIMEOUT_EN.
- Defined: in RX_KEY or ACTIVE, a partial frame (bit counter >0) with no validCmd for TIMEOUT consecutive cycles is discarded and the bit counter cleared. Failure count, keyError, active and mode are unchanged.
- Not defined: partial frames are held indefinitely. TIMEOUT is unused and no idle counter is built.

Test Plan:
- Reset, then send bits 1,0,1,0,1,1 on consecutive validCmd cycles -> active=1 and mode=2'b11 at the sixth bit's edge; keyError stays 0.
- Send 0,0,1,0,x,x -> keyError pulses once at the sixth edge; active=0. Then send the correct frame 1,0,1,0,0,1 -> active=1, mode=2'b10, failure count back to 0.
- Three consecutive bad frames -> locked=1 at the third frame's last edge. A correct frame sent during lockout is ignored. locked=0 after exactly 16 cycles; a correct frame then gives active=1.
- While ACTIVE, send 1 then 0 -> mode stays at its old value after the first bit and becomes 2'b01 after the second.
- While ACTIVE, assert clear and validCmd in the same cycle -> active=0, mode=0, state RX_KEY, bit ignored.
- Send 1,0,1, assert reset_n=0 mid-frame, release, send 1,0,1,0,1,0 -> active=1, mode=2'b01. With SKD_TIMEOUT_EN defined: send 1,0, idle 32 cycles, then send a full correct frame -> accepted.
